// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants, types and lane helpers.
// Lane (x,y) occupies bits [(5*y+x)*64 +: 64] of the flat state.
package keccak_pkg;

    localparam int LANE_W     = 64;
    localparam int STATE_W    = 1600;
    localparam int NUM_ROUNDS = 24;
    localparam int COL_W      = 5 * LANE_W;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [COL_W-1:0]   cols_t;

    function automatic int idx(input int x, input int y);
        return (5 * y + x) * LANE_W;
    endfunction

    // Column parities: C[x] lives in bits [x*64 +: 64].
    function automatic cols_t col_parity(input state_t s);
        cols_t c;
        c = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                c[x*LANE_W +: LANE_W] = c[x*LANE_W +: LANE_W] ^ s[idx(x, y) +: LANE_W];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/keccak_theta_comb.sv
// Combinational theta mix: builds D from precomputed column parities and applies it.
// Kept free of state so an iterative round core can reuse it.
module keccak_theta_comb
    import keccak_pkg::*;
(
    input  state_t state_i,
    input  cols_t  c_i,
    output state_t state_o
);

    lane_t [4:0] d;

    // D[x] = C[x-1] ^ rotl1(C[x+1]); rotl1 maps bit k to bit k+1.
    for (genvar x = 0; x < 5; x++) begin : g_d
        lane_t cm1;
        lane_t cp1;
        assign cm1  = c_i[((x + 4) % 5)*LANE_W +: LANE_W];
        assign cp1  = c_i[((x + 1) % 5)*LANE_W +: LANE_W];
        assign d[x] = cm1 ^ {cp1[LANE_W-2:0], cp1[LANE_W-1]};
    end

    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar x = 0; x < 5; x++) begin : g_x
            assign state_o[(5*y+x)*LANE_W +: LANE_W] = state_i[(5*y+x)*LANE_W +: LANE_W] ^ d[x];
        end
    end

endmodule

// File: rtl/keccak_theta_pipe.sv
// Two-stage registered theta: stage 1 captures state and column parities,
// stage 2 holds the mixed state so the downstream rho path starts from flops.
module keccak_theta_pipe
    import keccak_pkg::*;
#(
    parameter int ROUND_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [ROUND_W-1:0] in_round,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_last
);

    state_t               s1_state_q, s2_state_q, s2_state_d;
    cols_t                s1_c_q, s1_c_d;
    logic [ROUND_W-1:0]   s1_round_q, s2_round_q;
    logic                 s1_last_q, s2_last_q;
    logic                 s1_valid_q, s2_valid_q;
    logic                 adv1, adv2;

    // Ready depends only on valid flops and out_ready, never on in_valid.
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    assign s1_c_d = col_parity(in_state);

    keccak_theta_comb u_theta (
        .state_i (s1_state_q),
        .c_i     (s1_c_q),
        .state_o (s2_state_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_state_q <= '0;
            s1_c_q     <= '0;
            s1_round_q <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_state_q <= '0;
            s2_round_q <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_state_q <= in_state;
                    s1_c_q     <= s1_c_d;
                    s1_round_q <= in_round;
                    s1_last_q  <= in_last;
                end
            end
            // adv2 is low only while a valid beat is stalled, keeping s2 stable.
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                s2_state_q <= s2_state_d;
                s2_round_q <= s1_round_q;
                s2_last_q  <= s1_last_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_state = s2_state_q;
    assign out_round = s2_round_q;
    assign out_last  = s2_last_q;

endmodule
